// File: rtl/systolic_skew_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder_if
// Purpose  : Tile-control, beat-handshake and skewed edge-lane bundle between
//            a tile source (master) and the systolic skew feeder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface systolic_skew_feeder_if #(
  parameter int N  = 4,
  parameter int KW = 16
);
  logic            start;
  logic [KW-1:0]   k_len;
  logic            s_valid;
  logic            s_ready;
  logic [N*8-1:0]  s_a;
  logic [N*8-1:0]  s_b;
  logic [N*8-1:0]  out_a;
  logic [N*8-1:0]  out_b;
  logic            process;
  logic            busy;
  logic            done;

  modport master (
    output start, k_len, s_valid, s_a, s_b,
    input  s_ready, out_a, out_b, process, busy, done
  );

  modport slave (
    input  start, k_len, s_valid, s_a, s_b,
    output s_ready, out_a, out_b, process, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Purpose  : Edge stage for an NxN 8-bit MAC PE array. Accepts K beats of
//            A/B lane slices, applies triangular skew (lane i lags lane 0 by
//            i array steps), drives the array edge lanes plus the process
//            strobe, flushes 2N-2 zero steps and pulses done.
// Option   : SKEW_FEEDER_PERF_EN adds a 32-bit saturating stall_cnt output
//            counting LOAD cycles without a valid beat.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
  parameter int N  = 4,
  parameter int KW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_skew_feeder_if.slave bus
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  // Triangular storage: lane i owns stages [i(i+1)/2 .. i(i+1)/2 + i]
  localparam int NS = N * (N + 1) / 2;
  // Flush counter wide enough to count 0 .. 2N-3
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic            step;
  logic            accept;
  logic            start_ok;
  logic            ready;
  logic            process_q;
  logic [7:0]      stg_a [NS];
  logic [7:0]      stg_b [NS];
  logic [N*8-1:0]  edge_a;
  logic [N*8-1:0]  edge_b;

  // State register; async active-low reset forces IDLE mid-tile too
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the per-cycle step/accept/ready strobes
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    start_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          // A zero-length tile skips straight to the done cycle
          state_next = (bus.k_len != '0) ? LOAD : FIN;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (bus.s_valid) begin
          accept = 1'b1;
          step   = 1'b1;
          if (beat_cnt == k_reg - KW'(1)) begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        step = 1'b1;
        if (flush_cnt == FLUSH_LAST) begin
          state_next = FIN;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tile length latch, beat counter and flush step counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (start_ok) begin
        k_reg    <= bus.k_len;
        beat_cnt <= '0;
      end else if (accept) begin
        // Tops out at K, which always fits in KW bits
        beat_cnt <= beat_cnt + KW'(1);
      end
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + FW'(1);
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  // Process strobe lags the step by one cycle, matching the skew outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      process_q <= 1'b0;
    end else begin
      process_q <= step;
    end
  end

  // Skew shift registers: every lane advances only on a step; FLUSH injects 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NS; s++) begin
        stg_a[s] <= '0;
        stg_b[s] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        for (int j = i; j > 0; j--) begin
          stg_a[i * (i + 1) / 2 + j] <= stg_a[i * (i + 1) / 2 + j - 1];
          stg_b[i * (i + 1) / 2 + j] <= stg_b[i * (i + 1) / 2 + j - 1];
        end
        stg_a[i * (i + 1) / 2] <= accept ? bus.s_a[8 * i +: 8] : 8'h00;
        stg_b[i * (i + 1) / 2] <= accept ? bus.s_b[8 * i +: 8] : 8'h00;
      end
    end
  end

  // Last stage of each lane is that lane's array edge input
  always_comb begin
    edge_a = '0;
    edge_b = '0;
    for (int i = 0; i < N; i++) begin
      edge_a[8 * i +: 8] = stg_a[i * (i + 1) / 2 + i];
      edge_b[8 * i +: 8] = stg_b[i * (i + 1) / 2 + i];
    end
  end

  assign bus.out_a   = edge_a;
  assign bus.out_b   = edge_b;
  assign bus.process = process_q;
  assign bus.s_ready = ready;
  assign bus.busy    = (state != IDLE);
  // FIN always follows the last step, so done lines up with the last process
  assign bus.done    = (state == FIN);

`ifdef SKEW_FEEDER_PERF_EN
  // Saturating count of LOAD cycles spent waiting for a beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == LOAD) && !bus.s_valid && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // Stall counter not present in this build
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_skew_feeder
// Purpose  : Directed self-checking bench for systolic_skew_feeder (N=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_skew_feeder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   proc_cnt;
  int   p0;
  logic mdl_clr;

  systolic_skew_feeder_if #(.N(4), .KW(16)) bus ();

`ifdef SKEW_FEEDER_PERF_EN
  logic [31:0] stall_cnt;
`endif

  systolic_skew_feeder #(.N(4), .KW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef SKEW_FEEDER_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count process cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.process === 1'b1) proc_cnt <= proc_cnt + 1;
  end

  // Consumer PE-array model: a flows right, b flows down, MAC on process
  logic signed [7:0] pa  [4][4];
  logic signed [7:0] pb  [4][4];
  int                acc [4][4];
  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= 0;
        end
      end
    end else if (bus.process === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          logic signed [7:0] ain;
          logic signed [7:0] bin;
          int jm;
          int im;
          jm  = (j > 0) ? j - 1 : 0;
          im  = (i > 0) ? i - 1 : 0;
          ain = (j == 0) ? bus.out_a[8 * i +: 8] : pa[i][jm];
          bin = (i == 0) ? bus.out_b[8 * j +: 8] : pb[im][j];
          pa[i][j]  <= ain;
          pb[i][j]  <= bin;
          acc[i][j] <= acc[i][j] + int'(ain) * int'(bin);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, bus.done}, 64'd1);
  endtask

  logic [31:0] e1a [9];
  logic [31:0] e1b [9];
  logic [7:0]  e2l0 [8];
  logic [7:0]  e2l3 [8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    proc_cnt = 0;
    mdl_clr  = 1'b1;
    rst      = 1'b0;
    bus.start   = 1'b0;
    bus.k_len   = '0;
    bus.s_valid = 1'b0;
    bus.s_a     = '0;
    bus.s_b     = '0;

    e1a  = '{32'h00000001, 32'h00000102, 32'h00010203, 32'h01020300,
             32'h02030000, 32'h03000000, 32'h0, 32'h0, 32'h0};
    e1b  = '{32'h00000010, 32'h00001020, 32'h00102030, 32'h10203000,
             32'h20300000, 32'h30000000, 32'h0, 32'h0, 32'h0};
    e2l0 = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e2l3 = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0};

    // ---------------- reset state
    #12;
    chk("rst_out_a",   64'(bus.out_a), 64'd0);
    chk("rst_out_b",   64'(bus.out_b), 64'd0);
    chk("rst_process", 64'(bus.process), 64'd0);
    chk("rst_done",    64'(bus.done), 64'd0);
    chk("rst_busy",    64'(bus.busy), 64'd0);
    chk("rst_ready",   64'(bus.s_ready), 64'd0);
`ifdef SKEW_FEEDER_PERF_EN
    chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
    rst = 1'b1;

    // ---------------- test 1: K=3, continuous valid
    bus.start = 1'b1;
    bus.k_len = 16'd3;
    tick();
    bus.start = 1'b0;
    chk("t1_busy", 64'(bus.busy), 64'd1);
    p0 = proc_cnt;
    for (int c = 0; c < 9; c++) begin
      if (c < 3) begin
        bus.s_valid = 1'b1;
        bus.s_a = {4{8'(c + 1)}};
        bus.s_b = {4{8'((c + 1) * 16)}};
        chk("t1_ready_hi", 64'(bus.s_ready), 64'd1);
      end else begin
        bus.s_valid = 1'b0;
        chk("t1_ready_lo", 64'(bus.s_ready), 64'd0);
      end
      tick();
      chk("t1_out_a",    64'(bus.out_a), 64'(e1a[c]));
      chk("t1_out_b",    64'(bus.out_b), 64'(e1b[c]));
      chk("t1_process",  64'(bus.process), 64'd1);
      chk("t1_done",     64'(bus.done), (c == 8) ? 64'd1 : 64'd0);
    end
    tick();
    chk("t1_busy_end",  64'(bus.busy), 64'd0);
    chk("t1_proc_end",  64'(bus.process), 64'd0);
    chk("t1_done_end",  64'(bus.done), 64'd0);
    chk("t1_proc_cnt",  64'(proc_cnt - p0), 64'd9);

    // ---------------- test 2: K=2, PE-array model, A=beat+1, B lane j = j+1
    mdl_clr = 1'b1;
    tick();
    mdl_clr = 1'b0;
    bus.start = 1'b1;
    bus.k_len = 16'd2;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c < 2) begin
        bus.s_valid = 1'b1;
        bus.s_a = {4{8'(c + 1)}};
        bus.s_b = {8'd4, 8'd3, 8'd2, 8'd1};
      end else begin
        bus.s_valid = 1'b0;
      end
      tick();
      chk("t2_lane0", 64'(bus.out_a[7:0]), 64'(e2l0[c]));
      chk("t2_lane3", 64'(bus.out_a[31:24]), 64'(e2l3[c]));
    end
    chk("t2_done", 64'(bus.done), 64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        chk("t2_mac", 64'(acc[i][j]), 64'(3 * (j + 1)));
      end
    end

    // ---------------- test 3: stall, ignored start, sign pass-through
    p0 = proc_cnt;
    bus.s_b = '0;
    bus.start = 1'b1;
    bus.k_len = 16'd3;
    tick();
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_a = {4{8'h80}};
    tick();
    chk("t3_beat1", 64'(bus.out_a), 64'h00000080);
    bus.s_valid = 1'b0;
    bus.start = 1'b1;
    bus.k_len = 16'd7;
    for (int c = 0; c < 5; c++) begin
      chk("t3_stall_ready", 64'(bus.s_ready), 64'd1);
      tick();
      bus.start = 1'b0;
      chk("t3_stall_proc",   64'(bus.process), 64'd0);
      chk("t3_stall_frozen", 64'(bus.out_a), 64'h00000080);
    end
    bus.s_valid = 1'b1;
    bus.s_a = {4{8'h7F}};
    tick();
    chk("t3_beat2", 64'(bus.out_a), 64'h0000807F);
    bus.s_a = {4{8'h01}};
    tick();
    chk("t3_beat3", 64'(bus.out_a), 64'h00807F01);
    bus.s_valid = 1'b0;
    wait_done("t3_done");
    tick();
    chk("t3_proc_cnt", 64'(proc_cnt - p0), 64'd9);
`ifdef SKEW_FEEDER_PERF_EN
    chk("t3_stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // ---------------- test 4: k_len = 0
    p0 = proc_cnt;
    bus.start = 1'b1;
    bus.k_len = 16'd0;
    tick();
    bus.start = 1'b0;
    chk("t4_done",    64'(bus.done), 64'd1);
    chk("t4_busy",    64'(bus.busy), 64'd1);
    chk("t4_process", 64'(bus.process), 64'd0);
    tick();
    chk("t4_done_end", 64'(bus.done), 64'd0);
    chk("t4_busy_end", 64'(bus.busy), 64'd0);
    chk("t4_proc_cnt", 64'(proc_cnt - p0), 64'd0);
`ifdef SKEW_FEEDER_PERF_EN
    chk("t4_stall_clr", 64'(stall_cnt), 64'd0);
`endif

    // ---------------- test 5: async reset during FLUSH, then K=1
    bus.start = 1'b1;
    bus.k_len = 16'd2;
    tick();
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_a = {4{8'h11}};
    tick();
    bus.s_a = {4{8'h22}};
    tick();
    bus.s_valid = 1'b0;
    tick();
    tick();
    chk("t5_pre_rst", 64'(bus.out_a), 64'h11220000);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_out_a", 64'(bus.out_a), 64'd0);
    chk("t5_rst_proc",  64'(bus.process), 64'd0);
    chk("t5_rst_busy",  64'(bus.busy), 64'd0);
    chk("t5_rst_ready", 64'(bus.s_ready), 64'd0);
    #2;
    rst = 1'b1;
    tick();
    chk("t5_idle", 64'(bus.busy), 64'd0);
    p0 = proc_cnt;
    bus.start = 1'b1;
    bus.k_len = 16'd1;
    tick();
    bus.start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_a = {4{8'h5A}};
    tick();
    bus.s_valid = 1'b0;
    chk("t5_k1_lane0", 64'(bus.out_a), 64'h0000005A);
    wait_done("t5_done");
    tick();
    chk("t5_proc_cnt", 64'(proc_cnt - p0), 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Edge stage that directly feeds the N-row/N-column 8-bit signed MAC PE array.
- Accepts one A column-slice and one B row-slice per handshake: N lanes each, a k-index per beat.
- Applies triangular skew so lane i lags lane 0 by i array steps, then drives the array's in_a/in_b edge lanes and the global process strobe.
- After the last beat, flushes zeros until every PE has absorbed all K products, then pulses done.

Parameters:
- N, 4, array dimension (lanes per side), 2..16.
- KW, 16, width of k_len and the internal beat counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin a tile; sampled only in IDLE.
- k_len  in  KW  number of beats K for this tile; sampled with start.
- s_valid  in  1  s_a/s_b beat valid.
- s_ready  out  1  feeder accepts a beat this cycle.
- s_a  in  N*8  A lanes, lane i = bits [8i+7:8i], signed.
- s_b  in  N*8  B lanes, same packing.
- out_a  out  N*8  skewed A lanes to array row edges.
- out_b  out  N*8  skewed B lanes to array column edges.
- process  out  1  global array advance strobe, registered.
- busy  out  1  high from accepted start until done cycle inclusive.
- done  out  1  one-cycle pulse, tile fully processed.

Behaviour:
- Reset (rst=0, any time, including mid-tile): state IDLE; all skew stages, out_a, out_b 0; process, done, busy, s_ready 0; beat counter cleared.
- FSM states: IDLE, LOAD, FLUSH, FIN.
- IDLE:
  - start=1 and k_len>0 → LOAD; latch K; busy=1.
  - start=1 and k_len=0 → FIN directly, with no process pulses.
  - start outside IDLE is ignored.
- LOAD:
  - s_ready=1 combinationally.
  - A beat is accepted when s_valid && s_ready; that cycle is a step.
  - s_valid=0 is a stall: no step, skew registers hold, next-cycle process=0.
  - After the K-th accepted beat → FLUSH.
- FLUSH:
  - s_ready=0.
  - Every cycle is a step that injects zeros into all lanes.
  - Exactly 2N-2 steps, then → FIN.
- FIN: done=1 for one cycle, aligned with the final process=1 cycle; busy drops the following cycle; → IDLE.
- Skew datapath:
  - Lane i has i+1 register stages; all stages shift only on a step.
  - A beat accepted at step s appears on lane i outputs in the cycle after step s+i.
- process(t+1) = step(t). Outputs hold between steps, so the array sees in_a/in_b stable whenever process=0.
- Total steps per tile = K + 2N - 2. Number of process=1 cycles equals this exactly.
- No arithmetic is performed; lanes are pure 8-bit pass-through, sign preserved.
- Beat counter is KW bits; the K = 2^KW - 1 maximum is supported without wrap.
- done and start in the same cycle: start is ignored (state ≠ IDLE).

Optional Feature:
- Macro SKEW_FEEDER_PERF_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits.
  - Counts LOAD cycles with s_valid=0.
  - Cleared on accepted start; saturates at all-ones; holds after done; 0 on reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- N=4, K=3, s_valid held 1 → s_ready high 3 cycles; process high 9 consecutive cycles; done coincides with 9th; lane 3 first beat appears 4 cycles after first acceptance.
- N=4, K=2, lane values A=beat index+1 → out_a lane0 shows 1,2,0,0..., lane3 shows 0,0,0,1,2,0...; feeding a PE-array model yields C = A·B exactly, e.g. all-ones K=2 → every mac = 2.
- N=4, K=3, s_valid=0 for 5 cycles between beats 1 and 2 → process=0 for those cycles, outputs frozen, total process=1 count still 9; with SKEW_FEEDER_PERF_EN stall_cnt=5.
- k_len=0 with start → done pulses the next cycle; process never asserts; busy high one cycle.
- rst deasserted-then-asserted low during FLUSH → all outputs 0 immediately; after release, start with K=1 completes normally with 7 process cycles.
- start pulsed while busy → ignored; K and process count unchanged; s_a values 0x80/0x7F pass through unaltered (sign check).
